// File: rtl/stego_pkg.sv
// Shared types and constants for the LSB steganography extractor.
package stego_pkg;
  localparam int STEGO_HDR_W  = 16;
  localparam int STEGO_WORD_W = 64;
  localparam int STEGO_CSUM_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CHK,
    ST_DONE
  } stego_state_t;
endpackage

// File: rtl/stego_bit_packer.sv
// MSB-first shift register with a bit counter; full marks the pixel that completes
// the current unit (header, word or trailer), whose length is set by last_pos.
module stego_bit_packer #(
  parameter int BITS_PER_PIX = 1,
  parameter int WORD_W       = 64,
  localparam int CW          = $clog2(WORD_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    accept,
  input  logic [BITS_PER_PIX-1:0] bits,
  input  logic [CW-1:0]           last_pos,
  output logic                    full,
  output logic [WORD_W-1:0]       assembled
);
  logic [WORD_W-1:0] shreg;
  logic [CW-1:0]     cnt;

  assign full      = (cnt == last_pos);
  // value including the pixel presented this cycle, so the top can latch it on the edge
  assign assembled = {shreg[WORD_W-BITS_PER_PIX-1:0], bits};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= assembled;
      cnt   <= full ? '0 : cnt + CW'(BITS_PER_PIX);
    end
  end
endmodule

// File: rtl/stego_lsb_extract.sv
// Recovers a length header and ciphertext words from pixel LSBs with a one-word skid.
// Define STEGO_CHECKSUM_EN to read and verify an 8-bit XOR trailer after the payload.
module stego_lsb_extract
  import stego_pkg::*;
#(
  parameter int BITS_PER_PIX = 1,
  parameter int PIX_W        = 8,
  parameter int WORD_W       = STEGO_WORD_W,
  parameter int HDR_W        = STEGO_HDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [HDR_W-1:0]  msg_len,
  output logic              busy,
  output logic              done
`ifdef STEGO_CHECKSUM_EN
  ,
  output logic              chk_err
`endif
);
  localparam int CW = $clog2(WORD_W);
`ifdef STEGO_CHECKSUM_EN
  localparam stego_state_t ST_FIN = ST_CHK;
`else
  localparam stego_state_t ST_FIN = ST_DONE;
`endif

  stego_state_t      state, state_nxt;
  logic [HDR_W-1:0]  word_cnt;
  logic [CW-1:0]     last_pos;
  logic              accept, full, start_go, unit_done;
  logic [WORD_W-1:0] assembled;

  assign start_go  = (state == ST_IDLE) && start;
  assign accept    = pix_valid && pix_ready;
  assign unit_done = accept && full;
  assign busy      = (state == ST_HDR) || (state == ST_PAYLOAD) || (state == ST_CHK);
  assign done      = (state == ST_DONE);

  stego_bit_packer #(
    .BITS_PER_PIX(BITS_PER_PIX),
    .WORD_W      (WORD_W)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (start_go),
    .accept   (accept),
    .bits     (pix_in[BITS_PER_PIX-1:0]),
    .last_pos (last_pos),
    .full     (full),
    .assembled(assembled)
  );

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    last_pos  = CW'(WORD_W - BITS_PER_PIX);
    case (state)
      ST_IDLE: if (start) state_nxt = ST_HDR;
      ST_HDR: begin
        pix_ready = 1'b1;
        last_pos  = CW'(HDR_W - BITS_PER_PIX);
        if (pix_valid && full)
          state_nxt = (assembled[HDR_W-1:0] == '0) ? ST_FIN : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        // stall only the word-completing pixel while the output slot is still occupied
        pix_ready = (word_cnt != msg_len) && !(full && word_valid && !word_ready);
        if ((word_cnt == msg_len) && (!word_valid || word_ready)) state_nxt = ST_FIN;
      end
`ifdef STEGO_CHECKSUM_EN
      ST_CHK: begin
        pix_ready = 1'b1;
        last_pos  = CW'(STEGO_CSUM_W - BITS_PER_PIX);
        if (pix_valid && full) state_nxt = ST_DONE;
      end
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      word_out   <= '0;
      word_valid <= 1'b0;
      msg_len    <= '0;
      word_cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (start_go) begin
        msg_len  <= '0;
        word_cnt <= '0;
      end
      if (state == ST_HDR && unit_done) msg_len <= assembled[HDR_W-1:0];
      // reload wins over drain, so a same-cycle drain+reload keeps word_valid high
      if (state == ST_PAYLOAD && unit_done) begin
        word_out   <= assembled;
        word_valid <= 1'b1;
        word_cnt   <= word_cnt + HDR_W'(1);
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

`ifdef STEGO_CHECKSUM_EN
  logic [STEGO_CSUM_W-1:0] csum, word_xor;

  always_comb begin
    word_xor = '0;
    for (int i = 0; i < WORD_W / STEGO_CSUM_W; i++)
      word_xor = word_xor ^ assembled[i*STEGO_CSUM_W +: STEGO_CSUM_W];
  end

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      csum    <= '0;
      chk_err <= 1'b0;
    end else begin
      if (state == ST_PAYLOAD && unit_done) csum <= csum ^ word_xor;
      if (state == ST_CHK && unit_done) chk_err <= (assembled[STEGO_CSUM_W-1:0] != csum);
    end
  end
`endif
endmodule

// File: tb/tb_stego_lsb_extract.sv
// Table-driven bench for stego_lsb_extract (1- and 2-bit-per-pixel instances) with a word scoreboard.
module tb_stego_lsb_extract;
  import stego_pkg::*;

  typedef struct {
    int          bpp;
    logic [15:0] hdr;
    logic [63:0] w0, w1, w2;
    int          stall;
    bit          gap;
    bit          bad;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [7:0]  pix_in = 8'h00;
  logic        pix_valid = 1'b0;
  logic        word_ready = 1'b1;
  logic        pr1, pr2, wv1, wv2, bz1, bz2, dn1, dn2;
  logic [63:0] wo1, wo2;
  logic [15:0] ml1, ml2;
  logic        c_pr, c_wv, c_bz, c_dn;
  logic [63:0] c_wo;
  logic [15:0] c_ml;
`ifdef STEGO_CHECKSUM_EN
  logic        ce1, ce2, c_ce;
`endif

  always #5 clk = ~clk;

  stego_lsb_extract #(.BITS_PER_PIX(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr1), .word_out(wo1), .word_valid(wv1), .word_ready(word_ready),
    .msg_len(ml1), .busy(bz1), .done(dn1)
`ifdef STEGO_CHECKSUM_EN
    , .chk_err(ce1)
`endif
  );

  stego_lsb_extract #(.BITS_PER_PIX(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pr2), .word_out(wo2), .word_valid(wv2), .word_ready(word_ready),
    .msg_len(ml2), .busy(bz2), .done(dn2)
`ifdef STEGO_CHECKSUM_EN
    , .chk_err(ce2)
`endif
  );

  int sel = 1;
  assign c_pr = (sel == 2) ? pr2 : pr1;
  assign c_wv = (sel == 2) ? wv2 : wv1;
  assign c_bz = (sel == 2) ? bz2 : bz1;
  assign c_dn = (sel == 2) ? dn2 : dn1;
  assign c_wo = (sel == 2) ? wo2 : wo1;
  assign c_ml = (sel == 2) ? ml2 : ml1;
`ifdef STEGO_CHECKSUM_EN
  assign c_ce = (sel == 2) ? ce2 : ce1;
`endif

  logic [63:0] exp_q[$];
  logic [7:0]  pix_q[$];
  int nvec = 0, nerr = 0;
  int cyc = 0, done_cnt, done_cyc, first_wv_cyc, wlast_cyc, last_cyc;
  int blk_cnt, blk_bad, blk_expect, pix_idx, wlast_idx, payload_end;
  int stall_left = 0, cur_stall = 0;
  logic        held_vld = 1'b0;
  logic [63:0] held_word = '0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mk(int bpp, logic [63:0] val, int b);
    logic [7:0] p;
    p = 8'($urandom);
    if (bpp == 1) p[0] = val[b];
    else begin
      p[1] = val[b];
      p[0] = val[b-1];
    end
    return p;
  endfunction

  // post-edge sampling: done pulses, first word_valid, held-word stability
  task automatic edge_();
    @(posedge clk);
    #1;
    cyc++;
    if (c_dn) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (c_wv && first_wv_cyc < 0) begin
      first_wv_cyc = cyc;
      if (cur_stall > 0) stall_left = cur_stall;
    end
    if (held_vld) begin
      check("hold_valid", 64'(c_wv), 64'd1);
      check("hold_data", c_wo, held_word);
    end
  endtask

  // after inputs are driven: resolve the handshakes that the next edge will perform
  task automatic settle();
    #1;
    held_vld = 1'b0;
    if (c_wv && word_ready) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL extra_word: got %h expected none", c_wo);
      end else check("word", c_wo, exp_q.pop_front());
    end else if (c_wv) begin
      held_vld  = 1'b1;
      held_word = c_wo;
    end
    if (pix_valid && c_pr) begin
      if (pix_idx == wlast_idx) wlast_cyc = cyc;
      pix_idx++;
      pix_q.delete(0);
      if (pix_q.size() == 0) last_cyc = cyc;
    end else if (pix_valid && !c_pr && c_bz && pix_idx < payload_end) begin
      blk_cnt++;
      if (pix_idx != blk_expect) blk_bad++;
    end
    if (stall_left > 0) stall_left--;
  endtask

  task automatic run(vec_t v, int abort_at);
    int wpix, hdr_pix, n, post;
    logic [63:0] w, hv;
    logic [7:0] cs;
    sel = (v.bpp == 2) ? 2 : 1;
    wpix = 64 / v.bpp;
    hdr_pix = 16 / v.bpp;
    pix_q.delete();
    exp_q.delete();
    cs = 8'h00;
    hv = 64'(v.hdr);
    for (int b = 15; b >= 0; b -= v.bpp) pix_q.push_back(mk(v.bpp, hv, b));
    for (int i = 0; i < int'(v.hdr); i++) begin
      w = (i == 0) ? v.w0 : (i == 1) ? v.w1 : v.w2;
      exp_q.push_back(w);
      for (int k = 0; k < 8; k++) cs = cs ^ w[8*k +: 8];
      for (int b = 63; b >= 0; b -= v.bpp) pix_q.push_back(mk(v.bpp, w, b));
    end
`ifdef STEGO_CHECKSUM_EN
    hv = 64'(v.bad ? (cs ^ 8'h1F) : cs);
    for (int b = 7; b >= 0; b -= v.bpp) pix_q.push_back(mk(v.bpp, hv, b));
`endif
    done_cnt = 0; done_cyc = -1; first_wv_cyc = -1; wlast_cyc = -1; last_cyc = -1;
    blk_cnt = 0; blk_bad = 0; pix_idx = 0; held_vld = 1'b0; stall_left = 0;
    cur_stall = v.stall;
    wlast_idx = hdr_pix + wpix - 1;
    payload_end = hdr_pix + int'(v.hdr) * wpix;
    blk_expect = hdr_pix + 2 * wpix - 1;

    edge_();
    if (sel == 2) start2 = 1'b1; else start1 = 1'b1;
    pix_valid = 1'b0;
    word_ready = 1'b1;
    settle();
    n = 0;
    post = 0;
    forever begin
      edge_();
      start1 = 1'b0;
      start2 = 1'b0;
      n++;
      if (done_cnt > 0) post++;
      if (post > 3 || n > 3000 || (abort_at >= 0 && pix_idx >= abort_at)) break;
      pix_valid  = (pix_q.size() > 0) && (!v.gap || ($urandom_range(3) != 0));
      pix_in     = (pix_q.size() > 0) ? pix_q[0] : 8'h00;
      word_ready = (stall_left == 0);
      settle();
    end
    pix_valid = 1'b0;
    word_ready = 1'b1;
    if (abort_at < 0) begin
      check("timeout", 64'(n > 3000), 64'd0);
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("msg_len", 64'(c_ml), 64'(v.hdr));
      check("words_left", 64'(exp_q.size()), 64'd0);
      check("pix_left", 64'(pix_q.size()), 64'd0);
      if (v.hdr != 16'h0) check("first_word_latency", 64'(first_wv_cyc - wlast_cyc), 64'd1);
      else begin
        check("no_word_valid", 64'(first_wv_cyc), 64'(-1));
        check("done_latency", 64'(done_cyc - last_cyc), 64'd1);
      end
      if (v.stall > 0) begin
        check("bp_blocked", 64'(blk_cnt > 0), 64'd1);
        check("bp_block_pos", 64'(blk_bad), 64'd0);
      end else check("no_block", 64'(blk_cnt), 64'd0);
      check("idle_busy", 64'(c_bz), 64'd0);
`ifdef STEGO_CHECKSUM_EN
      check("chk_err", 64'(c_ce), 64'(v.bad));
`endif
    end
  endtask

  task automatic check_zero(string tag);
    check({tag, "_pix_ready"}, 64'(c_pr), 64'd0);
    check({tag, "_word_out"}, c_wo, 64'd0);
    check({tag, "_word_valid"}, 64'(c_wv), 64'd0);
    check({tag, "_msg_len"}, 64'(c_ml), 64'd0);
    check({tag, "_busy"}, 64'(c_bz), 64'd0);
    check({tag, "_done"}, 64'(c_dn), 64'd0);
`ifdef STEGO_CHECKSUM_EN
    check({tag, "_chk_err"}, 64'(c_ce), 64'd0);
`endif
  endtask

  vec_t tv [7];

  initial begin
    tv[0] = '{1, 16'h0001, 64'hC1F765C38141799E, 64'h0, 64'h0, 0, 1'b0, 1'b0};
    tv[1] = '{2, 16'h0002, 64'h85ABCD1A98876543, 64'h0123456789ABCDEF, 64'h0, 0, 1'b0, 1'b0};
    tv[2] = '{2, 16'h0002, 64'h85ABCD1A98876543, 64'h0123456789ABCDEF, 64'h0, 40, 1'b0, 1'b0};
    tv[3] = '{1, 16'h0000, 64'h0, 64'h0, 64'h0, 0, 1'b0, 1'b0};
    tv[4] = '{1, 16'h0001, 64'hC1F765C38141799E, 64'h0, 64'h0, 0, 1'b0, 1'b1};
    tv[5] = '{1, 16'h0003, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              0, 1'b1, 1'b0};
    tv[6] = '{2, 16'h0000, 64'h0, 64'h0, 64'h0, 0, 1'b0, 1'b1};

    rst = 1'b1;
    repeat (3) edge_();
    sel = 1;
    #0 check_zero("rst1");
    sel = 2;
    #1 check_zero("rst2");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run(tv[i], -1);

    // reset while the 30th pixel of word 1 has just been taken
    run(tv[0], 16 + 30);
    rst = 1'b1;
    settle();
    edge_();
    check_zero("midrst");
    rst = 1'b0;
    run(tv[0], -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
